// File: rtl/fir_coeff_pkg.sv
// Shared definitions for the FIR coefficient load controller: command word
// layout, opcodes, counter widths and FSM state encoding.
package fir_coeff_pkg;

  localparam int unsigned CMD_W        = 32;
  localparam int unsigned OP_W         = 3;
  localparam int unsigned ADDR_FIELD_W = 10;
  localparam int unsigned COEF_FIELD_W = 18;
  localparam int unsigned CMD_CNT_W    = 16;
  localparam int unsigned ERR_CNT_W    = 8;

  // Command field bit positions within the 32-bit register word.
  localparam int unsigned TOG_BIT  = 31;
  localparam int unsigned OP_MSB   = 30;
  localparam int unsigned OP_LSB   = 28;
  localparam int unsigned ADDR_MSB = 27;
  localparam int unsigned ADDR_LSB = 18;
  localparam int unsigned COEF_MSB = 17;
  localparam int unsigned COEF_LSB = 0;

  localparam logic [OP_W-1:0] OP_WRITE = 3'b001;
  localparam logic [OP_W-1:0] OP_CLEAR = 3'b010;
  localparam logic [OP_W-1:0] OP_SWAP  = 3'b011;

  // Decoded command without its toggle bit (what the FSM acts on).
  typedef struct packed {
    logic [OP_W-1:0]         op;
    logic [ADDR_FIELD_W-1:0] addr;
    logic [COEF_FIELD_W-1:0] coef;
  } cmd_payload_t;

  // Full register word: toggle bit on top of the payload.
  typedef struct packed {
    logic         tog;
    cmd_payload_t payload;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CLEAR = 3'd3,
    ST_ARMED = 3'd4
  } state_e;

endpackage

// File: rtl/fir_coeff_cmd_sync.sv
// Brings the asynchronously written command register into clk, qualifies it
// as stable, and flags a new command when its toggle differs from the last
// acknowledged toggle.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   reg_data     raw software command word (async to clk)
//   tog_ack      pulse: take the current word's toggle as the new reference
//   cmd_stable   registered: the sampled word has been steady for a cycle
//   cmd_valid    registered: stable word with an unacknowledged toggle
//   cmd          registered payload of the stable word
module fir_coeff_cmd_sync
  import fir_coeff_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] reg_data,
  input  logic             tog_ack,
  output logic             cmd_stable,
  output logic             cmd_valid,
  output cmd_payload_t     cmd
);

  logic [CMD_W-1:0] q1_q, q1_d;
  logic [CMD_W-1:0] q2_q, q2_d;
  logic [1:0]       fill_q, fill_d;
  logic             last_tog_q, last_tog_d;
  logic             stable_q, stable_d;
  logic             valid_q, valid_d;
  cmd_t             word_q, word_d;

  // Sampling pipe and qualification. fill_q keeps the reset values of the
  // sample stages from looking like a real stable word.
  always_comb begin
    q1_d       = reg_data;
    q2_d       = q1_q;
    fill_d     = {fill_q[0], 1'b1};
    stable_d   = fill_q[1] && (q1_q == q2_q);
    last_tog_d = tog_ack ? word_q.tog : last_tog_q;
    word_d     = cmd_t'(q2_q);
    // Compare against the post-ack toggle so an acknowledged word never
    // re-asserts valid on the following cycle.
    valid_d    = stable_d && (word_d.tog != last_tog_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q       <= '0;
      q2_q       <= '0;
      fill_q     <= '0;
      last_tog_q <= 1'b0;
      stable_q   <= 1'b0;
      valid_q    <= 1'b0;
      word_q     <= '0;
    end else begin
      q1_q       <= q1_d;
      q2_q       <= q2_d;
      fill_q     <= fill_d;
      last_tog_q <= last_tog_d;
      stable_q   <= stable_d;
      valid_q    <= valid_d;
      word_q     <= word_d;
    end
  end

  assign cmd_stable = stable_q;
  assign cmd_valid  = valid_q;
  assign cmd        = word_q.payload;

endmodule

// File: rtl/fir_coeff_load_ctrl.sv
// Sequences FIR coefficient loading into a double-buffered coefficient RAM:
// single-tap writes and full clears go to the shadow bank, and a swap makes
// the shadow bank active only on a datapath frame boundary.
// Ports:
//   user_clk, user_rst_n  clock, async active-low reset
//   reg_data              software command register (async)
//   frame_sync            one-cycle frame boundary pulse from the FIR
//   coef_we/bank/waddr/wdata  shadow-bank write port
//   active_bank           bank the FIR reads
//   busy, swap_pending, swap_done, cmd_count, err_count  status readback
module fir_coeff_load_ctrl
  import fir_coeff_pkg::*;
#(
  parameter int unsigned NUM_TAPS = 256,
  parameter int unsigned TAP_AW   = 8,
  parameter int unsigned COEF_W   = 18
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  input  logic [CMD_W-1:0]     reg_data,
  input  logic                 frame_sync,
  output logic                 coef_we,
  output logic                 coef_bank,
  output logic [TAP_AW-1:0]    coef_waddr,
  output logic [COEF_W-1:0]    coef_wdata,
  output logic                 active_bank,
  output logic                 busy,
  output logic                 swap_pending,
  output logic                 swap_done,
  output logic [CMD_CNT_W-1:0] cmd_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [TAP_AW-1:0] LAST_TAP = TAP_AW'(NUM_TAPS - 1);

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [TAP_AW-1:0]      waddr_q, waddr_d;
  logic [COEF_W-1:0]      wdata_q, wdata_d;
  logic                   bank_q, bank_d;
  logic                   wbank_q, wbank_d;
  logic                   busy_q, busy_d;
  logic                   pend_q, pend_d;
  logic                   sdone_q, sdone_d;
  logic [CMD_CNT_W-1:0]   cmd_cnt_q, cmd_cnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   tog_ack;
  logic                   err_inc;
  logic                   addr_ok;
  logic                   cmd_stable;
  logic                   cmd_valid;
  cmd_payload_t           cmd;

  fir_coeff_cmd_sync u_cmd_sync (
    .clk        (user_clk),
    .rst_n      (user_rst_n),
    .reg_data   (reg_data),
    .tog_ack    (tog_ack),
    .cmd_stable (cmd_stable),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd)
  );

  // Full-field compare also rejects any set upper address bit.
  assign addr_ok = 32'(cmd.addr) < NUM_TAPS;

  // Next-state and registered-output logic; outputs follow the next state.
  always_comb begin
    state_d   = state_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    bank_d    = bank_q;
    sdone_d   = 1'b0;
    cmd_cnt_d = cmd_cnt_q;
    err_cnt_d = err_cnt_q;
    tog_ack   = 1'b0;
    err_inc   = 1'b0;

    case (state_q)
      ST_SYNC: begin
        // Adopt the toggle present at reset without executing it.
        if (cmd_stable) begin
          tog_ack = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          tog_ack   = 1'b1;
          cmd_cnt_d = cmd_cnt_q + CMD_CNT_W'(1);
          case (cmd.op)
            OP_WRITE: begin
              if (addr_ok) begin
                state_d = ST_WRITE;
                we_d    = 1'b1;
                waddr_d = TAP_AW'(cmd.addr);
                wdata_d = COEF_W'(cmd.coef);
              end else begin
                err_inc = 1'b1;
              end
            end
            OP_CLEAR: begin
              state_d = ST_CLEAR;
              we_d    = 1'b1;
              waddr_d = '0;
              wdata_d = '0;
            end
            OP_SWAP: begin
              state_d = ST_ARMED;
            end
            default: begin
              err_inc = 1'b1;
            end
          endcase
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        // waddr_q doubles as the sweep counter.
        if (waddr_q == LAST_TAP) begin
          state_d = ST_IDLE;
        end else begin
          we_d    = 1'b1;
          waddr_d = waddr_q + TAP_AW'(1);
        end
      end
      ST_ARMED: begin
        if (frame_sync) begin
          bank_d  = ~bank_q;
          sdone_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase

    if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    wbank_d = ~bank_d;
    busy_d  = (state_d != ST_IDLE);
    pend_d  = (state_d == ST_ARMED);
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q   <= ST_SYNC;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      bank_q    <= 1'b0;
      wbank_q   <= 1'b1;
      busy_q    <= 1'b1;
      pend_q    <= 1'b0;
      sdone_q   <= 1'b0;
      cmd_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      bank_q    <= bank_d;
      wbank_q   <= wbank_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      sdone_q   <= sdone_d;
      cmd_cnt_q <= cmd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign coef_we      = we_q;
  assign coef_bank    = wbank_q;
  assign coef_waddr   = waddr_q;
  assign coef_wdata   = wdata_q;
  assign active_bank  = bank_q;
  assign busy         = busy_q;
  assign swap_pending = pend_q;
  assign swap_done    = sdone_q;
  assign cmd_count    = cmd_cnt_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// Directed bench for fir_coeff_load_ctrl. Cycle 0 is the cycle in which a new
// register word is first driven; inputs are driven and outputs sampled 1ns
// after the rising edge.
module tb_fir_coeff_load_ctrl;

  localparam int unsigned NUM_TAPS = 256;
  localparam int unsigned TAP_AW   = 8;
  localparam int unsigned COEF_W   = 18;

  logic                user_clk = 1'b0;
  logic                user_rst_n;
  logic [31:0]         reg_data;
  logic                frame_sync;
  logic                coef_we;
  logic                coef_bank;
  logic [TAP_AW-1:0]   coef_waddr;
  logic [COEF_W-1:0]   coef_wdata;
  logic                active_bank;
  logic                busy;
  logic                swap_pending;
  logic                swap_done;
  logic [15:0]         cmd_count;
  logic [7:0]          err_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 user_clk = ~user_clk;

  fir_coeff_load_ctrl #(
    .NUM_TAPS (NUM_TAPS),
    .TAP_AW   (TAP_AW),
    .COEF_W   (COEF_W)
  ) dut (
    .user_clk     (user_clk),
    .user_rst_n   (user_rst_n),
    .reg_data     (reg_data),
    .frame_sync   (frame_sync),
    .coef_we      (coef_we),
    .coef_bank    (coef_bank),
    .coef_waddr   (coef_waddr),
    .coef_wdata   (coef_wdata),
    .active_bank  (active_bank),
    .busy         (busy),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .cmd_count    (cmd_count),
    .err_count    (err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int we_seen;
    int we_bad;
    int addr_bad;
    int pend_bad;

    // Reset with a toggle already set: SYNC must absorb it.
    user_rst_n = 1'b0;
    reg_data   = 32'h8000_0000;
    frame_sync = 1'b0;
    step(3);
    check("rst_coef_we",      32'(coef_we),      32'd0);
    check("rst_coef_bank",    32'(coef_bank),    32'd1);
    check("rst_active_bank",  32'(active_bank),  32'd0);
    check("rst_busy",         32'(busy),         32'd1);
    check("rst_swap_pending", 32'(swap_pending), 32'd0);
    check("rst_swap_done",    32'(swap_done),    32'd0);
    check("rst_cmd_count",    32'(cmd_count),    32'd0);
    check("rst_err_count",    32'(err_count),    32'd0);
    check("rst_waddr",        32'(coef_waddr),   32'd0);
    check("rst_wdata",        32'(coef_wdata),   32'd0);

    user_rst_n = 1'b1;
    we_seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) check("sync_busy_c3", 32'(busy), 32'd1);
      if (c == 4) check("sync_busy_c4", 32'(busy), 32'd0);
      we_seen += int'(coef_we);
      tick();
    end
    check("sync_no_we",     32'(we_seen),   32'd0);
    check("sync_cmd_count", 32'(cmd_count), 32'd0);

    // WRITE tap 5 = 0x1ABCD with toggle flipped to 0.
    reg_data = 32'h1015_ABCD;
    step(3);
    check("wr_we_c3",     32'(coef_we),    32'd0);
    step(1);
    check("wr_we_c4",     32'(coef_we),    32'd1);
    check("wr_waddr",     32'(coef_waddr), 32'd5);
    check("wr_wdata",     32'(coef_wdata), 32'h1ABCD);
    check("wr_coef_bank", 32'(coef_bank),  32'd1);
    check("wr_cmd_count", 32'(cmd_count),  32'd1);
    step(1);
    check("wr_we_c5",     32'(coef_we),    32'd0);
    check("wr_busy_c5",   32'(busy),       32'd0);

    // Fresh reset, then WRITE to address 300: rejected.
    user_rst_n = 1'b0;
    reg_data   = 32'h0000_0000;
    step(2);
    user_rst_n = 1'b1;
    step(6);
    reg_data = 32'h94B0_0123;
    we_seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) begin
        check("bad_err_count", 32'(err_count), 32'd1);
        check("bad_cmd_count", 32'(cmd_count), 32'd1);
        check("bad_busy",      32'(busy),      32'd0);
      end
      we_seen += int'(coef_we);
      tick();
    end
    check("bad_no_we", 32'(we_seen), 32'd0);

    // CLEAR sweep; a WRITE issued mid-sweep runs afterwards.
    reg_data = 32'h2000_0000;
    we_bad   = 0;
    addr_bad = 0;
    for (int c = 0; c < 263; c++) begin
      if (coef_we !== (((c >= 4) && (c <= 259)) || (c == 261))) we_bad++;
      if ((c >= 4) && (c <= 259)) begin
        if ((coef_waddr !== TAP_AW'(c - 4)) || (coef_wdata !== '0)) addr_bad++;
      end
      if (c == 130) check("clr_busy_mid",  32'(busy),       32'd1);
      if (c == 259) check("clr_last_addr", 32'(coef_waddr), 32'd255);
      if (c == 260) check("clr_busy_done", 32'(busy),       32'd0);
      if (c == 261) begin
        check("clr_pend_waddr", 32'(coef_waddr), 32'd7);
        check("clr_pend_wdata", 32'(coef_wdata), 32'h42);
      end
      if (c == 50) reg_data = 32'h901C_0042;
      tick();
    end
    check("clr_we_pattern", 32'(we_bad),    32'd0);
    check("clr_addr_data",  32'(addr_bad),  32'd0);
    check("clr_cmd_count",  32'(cmd_count), 32'd3);
    check("clr_err_count",  32'(err_count), 32'd1);

    // SWAP; a stray frame_sync while IDLE is ignored, the one at cycle 14 swaps.
    reg_data = 32'h3000_0000;
    pend_bad = 0;
    for (int c = 0; c < 17; c++) begin
      if (c == 3) check("swp_pend_c3", 32'(swap_pending), 32'd0);
      if ((c >= 4) && (c <= 14)) begin
        if ((swap_pending !== 1'b1) || (active_bank !== 1'b0)) pend_bad++;
      end
      if (c == 15) begin
        check("swp_active_bank", 32'(active_bank),  32'd1);
        check("swp_done_pulse",  32'(swap_done),    32'd1);
        check("swp_coef_bank",   32'(coef_bank),    32'd0);
        check("swp_pend_clear",  32'(swap_pending), 32'd0);
        check("swp_busy",        32'(busy),         32'd0);
      end
      if (c == 16) check("swp_done_end", 32'(swap_done), 32'd0);
      frame_sync = (c == 1) || (c == 14);
      tick();
    end
    frame_sync = 1'b0;
    check("swp_pending_window", 32'(pend_bad), 32'd0);

    // SWAP whose acceptance coincides with frame_sync: next frame_sync swaps.
    reg_data = 32'hB000_0000;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) begin
        check("coin_pending", 32'(swap_pending), 32'd1);
        check("coin_no_swap", 32'(active_bank),  32'd1);
        check("coin_no_done", 32'(swap_done),    32'd0);
      end
      if (c == 7) begin
        check("coin_active_bank", 32'(active_bank), 32'd0);
        check("coin_done",        32'(swap_done),   32'd1);
        check("coin_coef_bank",   32'(coef_bank),   32'd1);
      end
      if (c == 8) check("coin_busy", 32'(busy), 32'd0);
      frame_sync = (c == 3) || (c == 6);
      tick();
    end
    frame_sync = 1'b0;

    // NOP: counted as both a command and an error.
    reg_data = 32'h0000_0000;
    step(5);
    check("nop_cmd_count", 32'(cmd_count), 32'd6);
    check("nop_err_count", 32'(err_count), 32'd2);
    check("nop_no_we",     32'(coef_we),   32'd0);

    // 260 more NOPs: err_count saturates, cmd_count keeps counting.
    for (int i = 0; i < 260; i++) begin
      reg_data = (i % 2 == 0) ? 32'h8000_0000 : 32'h0000_0000;
      step(6);
    end
    check("sat_err_count", 32'(err_count), 32'd255);
    check("sat_cmd_count", 32'(cmd_count), 32'd266);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
